// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for the 8-bit core.
// It advances ProgCtr each RUN cycle by incrementing, by taking a PC-relative
// branch through a programmable offset table, or by stopping on halt. It also
// runs the Start/Done program handshake and counts retired instructions.
module pc_sequencer #(
    parameter int PW = 10,
    parameter int LW = 5
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [PW-1:0] StartAddr,
    input  logic          Stall,
    input  logic          Halt,
    input  logic          BranchEn,
    input  logic          RelFlag,
    input  logic [LW-1:0] LutIdx,
    input  logic          LutWe,
    input  logic [LW-1:0] LutWrIdx,
    input  logic [PW-1:0] LutWrData,
    output logic [PW-1:0] ProgCtr,
    output logic          Running,
    output logic          Done,
    output logic          BranchTaken,
    output logic [15:0]   InstrCount
);

    localparam int LD = 1 << LW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          run_q, done_q;
    logic [PW-1:0] pc_q, pc_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          bt_q, bt_d;
    logic [PW-1:0] lut_q [LD];

    logic          lut_we_s;
    logic [PW-1:0] offset_s;

    // The offset is as wide as the PC, so a plain modulo-2^PW add is the
    // sign-extended add: negative offsets wrap backwards naturally.
    assign offset_s = lut_q[LutIdx];

    // A running program cannot rewrite its own branch table.
    assign lut_we_s = LutWe && (state_q != S_RUN);

    // State register; Running/Done are registered from the next state so
    // they never decode through combinational logic.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= (state_d == S_RUN);
            done_q  <= (state_d == S_DONE);
        end
    end

    // Next-state logic: Start is honoured only outside RUN; a non-stalled
    // Halt ends the program.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    state_d = S_RUN;
                end else begin
                    state_d = state_q;
                end
            end
            S_RUN: begin
                if (!Stall && Halt) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: PC update priority is halt, taken branch, step.
    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        bt_d  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    pc_d  = StartAddr;
                    cnt_d = 16'd0;
                end else begin
                    pc_d  = pc_q;
                    cnt_d = cnt_q;
                end
            end
            S_RUN: begin
                if (Stall) begin
                    pc_d  = pc_q;
                    cnt_d = cnt_q;
                end else begin
                    if (cnt_q != 16'hFFFF) begin
                        cnt_d = cnt_q + 16'd1;
                    end else begin
                        cnt_d = cnt_q;
                    end
                    if (Halt) begin
                        pc_d = pc_q;
                    end else if (BranchEn && RelFlag) begin
                        pc_d = pc_q + offset_s;
                        bt_d = 1'b1;
                    end else begin
                        pc_d = pc_q + {{(PW-1){1'b0}}, 1'b1};
                    end
                end
            end
            default: begin
                pc_d  = pc_q;
                cnt_d = cnt_q;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc_q  <= {PW{1'b0}};
            cnt_q <= 16'd0;
            bt_q  <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
            bt_q  <= bt_d;
        end
    end

    // Branch-offset table; cleared by reset, writable only outside RUN.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < LD; i++) begin
                lut_q[i] <= {PW{1'b0}};
            end
        end else if (lut_we_s) begin
            lut_q[LutWrIdx] <= LutWrData;
        end
    end

    assign ProgCtr     = pc_q;
    assign Running     = run_q;
    assign Done        = done_q;
    assign BranchTaken = bt_q;
    assign InstrCount  = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed stimulus, a behavioural reference
// model compared every cycle, and hand-computed literal expectations.
module tb_pc_sequencer;

    localparam int PW = 10;
    localparam int LW = 5;
    localparam int PCMOD = 1 << PW;

    logic          Clk = 1'b0;
    logic          Reset = 1'b0;
    logic          Start = 1'b0;
    logic [PW-1:0] StartAddr = '0;
    logic          Stall = 1'b0;
    logic          Halt = 1'b0;
    logic          BranchEn = 1'b0;
    logic          RelFlag = 1'b0;
    logic [LW-1:0] LutIdx = '0;
    logic          LutWe = 1'b0;
    logic [LW-1:0] LutWrIdx = '0;
    logic [PW-1:0] LutWrData = '0;
    logic [PW-1:0] ProgCtr;
    logic          Running;
    logic          Done;
    logic          BranchTaken;
    logic [15:0]   InstrCount;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    pc_sequencer #(.PW(PW), .LW(LW)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
        .Stall(Stall), .Halt(Halt), .BranchEn(BranchEn), .RelFlag(RelFlag),
        .LutIdx(LutIdx), .LutWe(LutWe), .LutWrIdx(LutWrIdx),
        .LutWrData(LutWrData), .ProgCtr(ProgCtr), .Running(Running),
        .Done(Done), .BranchTaken(BranchTaken), .InstrCount(InstrCount)
    );

    always #5 Clk = ~Clk;

    // ---------------- reference model (plain integer arithmetic) ----------
    int m_pc = 0;
    int m_cnt = 0;
    bit m_run = 1'b0;
    bit m_done = 1'b0;
    bit m_bt = 1'b0;
    int m_lut [1 << LW];

    function automatic int signed_off(input int raw);
        return (raw >= PCMOD / 2) ? raw - PCMOD : raw;
    endfunction

    function automatic int wrap_pc(input int v);
        return ((v % PCMOD) + PCMOD) % PCMOD;
    endfunction

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_pc <= 0; m_cnt <= 0; m_run <= 1'b0; m_done <= 1'b0; m_bt <= 1'b0;
            for (int i = 0; i < (1 << LW); i++) m_lut[i] <= 0;
        end else if (!m_run) begin
            m_bt <= 1'b0;
            if (LutWe) m_lut[LutWrIdx] <= int'(LutWrData);
            if (Start) begin
                m_pc <= int'(StartAddr); m_cnt <= 0; m_run <= 1'b1; m_done <= 1'b0;
            end
        end else if (Stall) begin
            m_bt <= 1'b0;
        end else begin
            m_bt <= 1'b0;
            if (m_cnt < 65535) m_cnt <= m_cnt + 1;
            if (Halt) begin
                m_run <= 1'b0; m_done <= 1'b1;
            end else if (BranchEn && RelFlag) begin
                m_pc <= wrap_pc(m_pc + signed_off(m_lut[LutIdx]));
                m_bt <= 1'b1;
            end else begin
                m_pc <= wrap_pc(m_pc + 1);
            end
        end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge Clk) begin
        if (chk_en) begin
            checks++;
            if (ProgCtr !== PW'(m_pc) || Running !== m_run || Done !== m_done ||
                BranchTaken !== m_bt || InstrCount !== 16'(m_cnt)) begin
                failures++;
                $display("FAIL model_cmp t=%0t dut pc=%h run=%b done=%b bt=%b cnt=%h required pc=%h run=%b done=%b bt=%b cnt=%h",
                         $time, ProgCtr, Running, Done, BranchTaken, InstrCount,
                         PW'(m_pc), m_run, m_done, m_bt, 16'(m_cnt));
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check_lit(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge Clk);
        #1;
    endtask

    task automatic clear_ctl();
        Start = 1'b0; Stall = 1'b0; Halt = 1'b0; BranchEn = 1'b0;
        RelFlag = 1'b0; LutWe = 1'b0;
    endtask

    initial begin
        // ---- reset then start ----
        #1 Reset = 1'b1;
        tick(); tick();
        Reset = 1'b0;
        chk_en = 1'b1;
        check_lit("rst_pc", int'(ProgCtr), 0);
        check_lit("rst_run_done", int'({Running, Done, BranchTaken}), 0);
        check_lit("rst_cnt", int'(InstrCount), 0);

        // Start with a same-cycle table write: table[3]=9
        Start = 1'b1; StartAddr = 10'h010;
        LutWe = 1'b1; LutWrIdx = 5'd3; LutWrData = 10'd9;
        tick(); clear_ctl();
        check_lit("start_pc", int'(ProgCtr), 'h010);
        check_lit("start_run", int'(Running), 1);
        tick(); tick(); tick();
        check_lit("plain3_pc", int'(ProgCtr), 'h013);
        check_lit("plain3_cnt", int'(InstrCount), 3);
        BranchEn = 1'b1; RelFlag = 1'b1; LutIdx = 5'd3;
        tick(); clear_ctl();
        check_lit("samecyc_wr_br", int'(ProgCtr), 'h01C);

        // asynchronous reset mid-RUN, checked before any clock edge
        #1 Reset = 1'b1;
        #1;
        check_lit("async_rst_pc", int'(ProgCtr), 0);
        check_lit("async_rst_flags", int'({Running, Done, BranchTaken}), 0);
        check_lit("async_rst_cnt", int'(InstrCount), 0);
        @(negedge Clk); #1;
        Reset = 1'b0;

        // ---- branch taken and not taken ----
        LutWe = 1'b1; LutWrIdx = 5'd2; LutWrData = 10'h3FC;
        tick(); clear_ctl();
        Start = 1'b1; StartAddr = 10'h020;
        tick(); clear_ctl();
        check_lit("br_start", int'(ProgCtr), 'h020);
        BranchEn = 1'b1; RelFlag = 1'b1; LutIdx = 5'd2;
        tick();
        check_lit("br_taken_pc", int'(ProgCtr), 'h01C);
        check_lit("br_taken_bt", int'(BranchTaken), 1);
        RelFlag = 1'b0;
        tick(); clear_ctl();
        check_lit("br_fall_pc", int'(ProgCtr), 'h01D);
        check_lit("br_fall_bt", int'(BranchTaken), 0);
        // table[3] was cleared by reset: offset 0 is a tight loop
        BranchEn = 1'b1; RelFlag = 1'b1; LutIdx = 5'd3;
        tick(); clear_ctl();
        check_lit("rst_table_pc", int'(ProgCtr), 'h01D);
        Halt = 1'b1;
        tick(); clear_ctl();
        check_lit("halt_done", int'({Running, Done}), 'b01);
        check_lit("halt_pc", int'(ProgCtr), 'h01D);

        // ---- wrap-around ----
        LutWe = 1'b1; LutWrIdx = 5'd5; LutWrData = 10'd5;
        Start = 1'b1; StartAddr = 10'h3FE;
        tick(); clear_ctl();
        check_lit("wrap_a", int'(ProgCtr), 'h3FE);
        tick();
        check_lit("wrap_b", int'(ProgCtr), 'h3FF);
        tick();
        check_lit("wrap_c", int'(ProgCtr), 'h000);
        Halt = 1'b1; tick(); clear_ctl();
        Start = 1'b1; StartAddr = 10'h3FD; tick(); clear_ctl();
        BranchEn = 1'b1; RelFlag = 1'b1; LutIdx = 5'd5;
        tick(); clear_ctl();
        check_lit("wrap_branch", int'(ProgCtr), 'h002);

        // ---- stall and halt priority ----
        Halt = 1'b1; tick(); clear_ctl();
        Start = 1'b1; StartAddr = 10'h040; tick(); clear_ctl();
        Stall = 1'b1; Halt = 1'b1; BranchEn = 1'b1; RelFlag = 1'b1; LutIdx = 5'd5;
        tick();
        tick();
        check_lit("stall_pc", int'(ProgCtr), 'h040);
        check_lit("stall_flags", int'({Running, Done, BranchTaken}), 'b100);
        check_lit("stall_cnt", int'(InstrCount), 0);
        Stall = 1'b0;
        tick(); clear_ctl();
        check_lit("prio_pc", int'(ProgCtr), 'h040);
        check_lit("prio_flags", int'({Running, Done, BranchTaken}), 'b010);
        check_lit("prio_cnt", int'(InstrCount), 1);

        // ---- ignored inputs in RUN ----
        Start = 1'b1; StartAddr = 10'h100; tick(); clear_ctl();
        Start = 1'b1; StartAddr = 10'h200;
        LutWe = 1'b1; LutWrIdx = 5'd0; LutWrData = 10'd7;
        tick(); clear_ctl();
        check_lit("ign_start_pc", int'(ProgCtr), 'h101);
        check_lit("ign_start_run", int'(Running), 1);
        Halt = 1'b1; tick(); clear_ctl();
        Start = 1'b1; StartAddr = 10'h080; tick(); clear_ctl();
        BranchEn = 1'b1; RelFlag = 1'b1; LutIdx = 5'd0;
        tick(); clear_ctl();
        check_lit("ign_lut_pc", int'(ProgCtr), 'h080);
        check_lit("ign_lut_bt", int'(BranchTaken), 1);

        // ---- counter saturation ----
        for (int i = 0; i < 65540; i++) tick();
        check_lit("sat_cnt", int'(InstrCount), 'hFFFF);
        Halt = 1'b1; tick(); clear_ctl();
        check_lit("sat_halt_cnt", int'(InstrCount), 'hFFFF);
        Start = 1'b1; StartAddr = 10'h000; tick(); clear_ctl();
        check_lit("sat_clear", int'(InstrCount), 0);
        // back-to-back: halt on first RUN cycle
        Halt = 1'b1; tick(); clear_ctl();
        check_lit("quick_halt", int'({Running, Done}), 'b01);
        check_lit("quick_halt_cnt", int'(InstrCount), 1);

        tick();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the 8-bit core. It sits on the consumer side of the ALU's branch-condition output, which drives `RelFlag` here. Each cycle it advances `ProgCtr`: it increments, takes a PC-relative branch through a programmable offset table, or stops on halt. It also runs the Start/Done program handshake with the testbench and counts retired instructions.

## Interface
- `PW`, default 10: program-counter width in bits.
- `LW`, default 5: branch-offset table index width; the table has 2^LW entries of PW bits each.
- `Clk` in 1: the single clock. All state updates on its rising edge.
- `Reset` in 1: asynchronous, active-high reset.
- `Start` in 1: begin program execution. Sampled only in IDLE and DONE.
- `StartAddr` in PW: first instruction address, loaded when Start is accepted.
- `Stall` in 1: freezes sequencing in RUN.
- `Halt` in 1: current instruction is a halt.
- `BranchEn` in 1: current instruction is a conditional branch (BHS class).
- `RelFlag` in 1: branch condition from the ALU.
- `LutIdx` in LW: offset-table index for the current branch.
- `LutWe` in 1: offset-table write enable.
- `LutWrIdx` in LW: write index.
- `LutWrData` in PW: write data, a signed two's-complement offset.
- `ProgCtr` out PW: current instruction address.
- `Running` out 1: high while in RUN.
- `Done` out 1: high while in DONE.
- `BranchTaken` out 1: one-cycle pulse following a taken branch.
- `InstrCount` out 16: instructions retired since the last accepted Start.

## Operation
- States are IDLE, RUN and DONE.
  - Reset puts the block in IDLE.
  - Reset values: ProgCtr=0, Running=0, Done=0, BranchTaken=0, InstrCount=0, all table entries 0.
- IDLE and DONE:
  - Start=1 at an edge does all of the following:
    - ProgCtr <= StartAddr;
    - InstrCount <= 0;
    - state <= RUN (Running=1, Done=0).
  - Without Start, all outputs hold.
- RUN, Stall=1: all registers hold, and Halt, BranchEn and LutIdx are ignored. BranchTaken goes to 0.
- RUN, Stall=0: exactly one action applies, in this priority order:
  1. Halt=1: ProgCtr holds, state <= DONE.
  2. BranchEn=1 and RelFlag=1: ProgCtr <= ProgCtr + sign-extended table[LutIdx], and BranchTaken <= 1.
  3. Otherwise: ProgCtr <= ProgCtr + 1.
- In each non-stalled RUN cycle, including the halt cycle, InstrCount increments. It saturates at 0xFFFF.
- BranchTaken is 0 in every cycle not covered by case 2.
- Start is ignored in RUN; a running program cannot be restarted except by Reset.
- PC arithmetic is modulo 2^PW:
  - ProgCtr + 1 wraps from 2^PW−1 to 0.
  - Offset addition wraps in both directions.
  - Offset 0 leaves the PC unchanged. This is a legal tight loop.
- BranchEn=1 with RelFlag=0 is a fall-through and is treated as case 3.
- Offset table:
  - Writes take effect only when the state is IDLE or DONE; LutWe in RUN is ignored.
  - A write in the same cycle Start is accepted still lands, and is visible from the first RUN cycle.
  - Reads are combinational from LutIdx, used only in RUN.
- Reset is asynchronous. Asserting it mid-RUN forces every output and every table entry to its reset value immediately, without waiting for a clock edge.

## Timing
- All outputs are registered. No output depends combinationally on any input.
- Start accepted at edge k: after edge k, ProgCtr=StartAddr and Running=1. The instruction at StartAddr is decoded during cycle k+1.
- Branch sampled at edge n with ProgCtr=P and offset D: after edge n, ProgCtr=P+D, and BranchTaken=1 for exactly that one cycle. There is no delay slot and no bubble.
- Halt sampled at edge n with ProgCtr=P: after edge n, Running=0, Done=1 and ProgCtr=P. Done stays high until a new Start is accepted.
- Minimum time from one Start to the next accepted Start: 2 edges (Start, then Halt on the first RUN cycle).

## Test plan
- Reset then start:
  - Stimulus: assert Reset mid-clock, release, then pulse Start with StartAddr=0x010.
  - Required: all outputs are 0 asynchronously during Reset. After the Start edge, ProgCtr=0x010 and Running=1. After 3 plain cycles, ProgCtr=0x013 and InstrCount=3.
- Branch taken and not taken:
  - Stimulus: in IDLE write table[2]=−4 (0x3FC). Start at 0x020. Next cycle drive BranchEn=1, RelFlag=1, LutIdx=2; then BranchEn=1, RelFlag=0.
  - Required: ProgCtr goes 0x020 → 0x01C with BranchTaken=1, then → 0x01D with BranchTaken=0.
- Wrap-around:
  - Stimulus: start at 0x3FE, run 2 plain cycles; then take a branch with offset +5 from 0x3FD.
  - Required: ProgCtr goes 0x3FE → 0x3FF → 0x000. The branch lands at 0x002.
- Stall and halt priority:
  - Stimulus: in RUN at ProgCtr=0x040, drive Stall=1 together with Halt=1 and a taken branch for 2 cycles. Then drop Stall, keeping Halt=1 and the taken branch.
  - Required: everything holds during the stall. Then ProgCtr stays 0x040, Done=1, Running=0, BranchTaken=0, and InstrCount increments by 1.
- Ignored inputs:
  - Stimulus: in RUN, pulse Start and write table[0]=7. Later halt, then restart with LutIdx=0 and a taken branch.
  - Required: Start has no effect in RUN. After restart, the branch offset is still 0 and the PC holds.
- Counter saturation:
  - Stimulus: run 65,540 plain cycles.
  - Required: InstrCount stops at 0xFFFF. A new Start clears it to 0.
